// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: tag width, source codes
// and the field widths of the per-source result bundles.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_ROB_SIZE_LOG = 4;
    localparam int unsigned CDB_VALUE_W      = 32;
    localparam int unsigned CDB_TARGET_W     = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    // ALU bundle packs {taken, target, value, robid}
    function automatic int unsigned alu_bundle_w(input int unsigned rob_w);
        return 1 + CDB_TARGET_W + CDB_VALUE_W + rob_w;
    endfunction

    // LSB bundle packs {value, robid}
    function automatic int unsigned lsb_bundle_w(input int unsigned rob_w);
        return CDB_VALUE_W + rob_w;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: push/pop/flush, exposes head, count and full.
// A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
module cdb_src_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign do_pop  = en_i && !flush_i && pop_i && (cnt_q != '0);
    assign do_push = en_i && !flush_i && push_i && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = full;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between the ALU and the
// load path; each source is buffered in its own small FIFO.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned ROB_SIZE_LOG = CDB_ROB_SIZE_LOG,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    pred_fail_flag,
    input  logic                    alu_valid,
    input  logic [31:0]             alu_value,
    input  logic [ROB_SIZE_LOG-1:0] alu_robid,
    input  logic                    alu_taken,
    input  logic [31:0]             alu_target,
    input  logic                    lsb_valid,
    input  logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_LOG-1:0] lsb_robid,
    output logic                    alu_stall,
    output logic                    lsb_stall,
    output logic                    cdb_valid,
    output logic [31:0]             cdb_value,
    output logic [ROB_SIZE_LOG-1:0] cdb_robid,
    output logic                    cdb_taken,
    output logic [31:0]             cdb_target,
    output logic                    cdb_src,
    output logic                    overflow_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ALU_W = alu_bundle_w(ROB_SIZE_LOG);
    localparam int unsigned LSB_W = lsb_bundle_w(ROB_SIZE_LOG);
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(FIFO_DEPTH - 1);

    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic [ALU_W-1:0] alu_head;
    logic [LSB_W-1:0] lsb_head;
    logic             alu_full, lsb_full;
    logic             alu_pop, lsb_pop;

    logic                    cdb_valid_q, cdb_valid_d;
    logic [31:0]             cdb_value_q, cdb_value_d;
    logic [ROB_SIZE_LOG-1:0] cdb_robid_q, cdb_robid_d;
    logic                    cdb_taken_q, cdb_taken_d;
    logic [31:0]             cdb_target_q, cdb_target_d;
    cdb_src_e                cdb_src_q, cdb_src_d;
    cdb_src_e                last_grant_q, last_grant_d;
    logic                    overflow_q, overflow_d;

    cdb_src_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst     (rst),
        .en_i    (rdy),
        .flush_i (pred_fail_flag),
        .push_i  (alu_valid),
        .data_i  ({alu_taken, alu_target, alu_value, alu_robid}),
        .pop_i   (alu_pop),
        .count_o (alu_cnt),
        .head_o  (alu_head),
        .full_o  (alu_full)
    );

    cdb_src_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk     (clk),
        .rst     (rst),
        .en_i    (rdy),
        .flush_i (pred_fail_flag),
        .push_i  (lsb_valid),
        .data_i  ({lsb_value, lsb_robid}),
        .pop_i   (lsb_pop),
        .count_o (lsb_cnt),
        .head_o  (lsb_head),
        .full_o  (lsb_full)
    );

    // Grant on pre-edge state; on a tie the source not granted last wins
    always_comb begin
        alu_pop = 1'b0;
        lsb_pop = 1'b0;
        if (alu_cnt != '0 && lsb_cnt != '0) begin
            alu_pop = (last_grant_q == SRC_LSB);
            lsb_pop = (last_grant_q == SRC_ALU);
        end else begin
            alu_pop = (alu_cnt != '0);
            lsb_pop = (lsb_cnt != '0);
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_value_d  = cdb_value_q;
        cdb_robid_d  = cdb_robid_q;
        cdb_taken_d  = cdb_taken_q;
        cdb_target_d = cdb_target_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        overflow_d   = overflow_q;
        if (rst || pred_fail_flag) begin
            cdb_valid_d  = 1'b0;
            cdb_value_d  = '0;
            cdb_robid_d  = '0;
            cdb_taken_d  = 1'b0;
            cdb_target_d = '0;
            cdb_src_d    = SRC_ALU;
            last_grant_d = SRC_LSB;
            if (rst) overflow_d = 1'b0;
        end else if (rdy) begin
            cdb_valid_d = alu_pop || lsb_pop;
            if (alu_pop) begin
                {cdb_taken_d, cdb_target_d, cdb_value_d, cdb_robid_d} = alu_head;
                cdb_src_d    = SRC_ALU;
                last_grant_d = SRC_ALU;
            end else if (lsb_pop) begin
                {cdb_value_d, cdb_robid_d} = lsb_head;
                cdb_taken_d  = 1'b0;
                cdb_target_d = '0;
                cdb_src_d    = SRC_LSB;
                last_grant_d = SRC_LSB;
            end
            if ((alu_valid && alu_full && !alu_pop) || (lsb_valid && lsb_full && !lsb_pop))
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cdb_valid_q  <= cdb_valid_d;
        cdb_value_q  <= cdb_value_d;
        cdb_robid_q  <= cdb_robid_d;
        cdb_taken_q  <= cdb_taken_d;
        cdb_target_q <= cdb_target_d;
        cdb_src_q    <= cdb_src_d;
        last_grant_q <= last_grant_d;
        overflow_q   <= overflow_d;
    end

    assign alu_stall    = (alu_cnt >= STALL_AT);
    assign lsb_stall    = (lsb_cnt >= STALL_AT);
    assign cdb_valid    = cdb_valid_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_robid    = cdb_robid_q;
    assign cdb_taken    = cdb_taken_q;
    assign cdb_target   = cdb_target_q;
    assign cdb_src      = cdb_src_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: latency, tie order, alternation,
// overflow, flush and rdy freeze.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, pred_fail_flag;
    logic        alu_valid, alu_taken, lsb_valid;
    logic [31:0] alu_value, alu_target, lsb_value;
    logic [3:0]  alu_robid, lsb_robid;
    logic        alu_stall, lsb_stall, cdb_valid, cdb_taken, cdb_src, overflow_err;
    logic [31:0] cdb_value, cdb_target;
    logic [3:0]  cdb_robid;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.ROB_SIZE_LOG(4), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .pred_fail_flag (pred_fail_flag),
        .alu_valid      (alu_valid),
        .alu_value      (alu_value),
        .alu_robid      (alu_robid),
        .alu_taken      (alu_taken),
        .alu_target     (alu_target),
        .lsb_valid      (lsb_valid),
        .lsb_value      (lsb_value),
        .lsb_robid      (lsb_robid),
        .alu_stall      (alu_stall),
        .lsb_stall      (lsb_stall),
        .cdb_valid      (cdb_valid),
        .cdb_value      (cdb_value),
        .cdb_robid      (cdb_robid),
        .cdb_taken      (cdb_taken),
        .cdb_target     (cdb_target),
        .cdb_src        (cdb_src),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_value = '0; alu_robid = '0; alu_taken = 1'b0; alu_target = '0;
        lsb_valid = 1'b0; lsb_value = '0; lsb_robid = '0;
    endtask

    task automatic push_a(input logic [31:0] v, input logic [3:0] r, input logic t, input logic [31:0] tg);
        alu_valid = 1'b1; alu_value = v; alu_robid = r; alu_taken = t; alu_target = tg;
    endtask

    task automatic push_l(input logic [31:0] v, input logic [3:0] r);
        lsb_valid = 1'b1; lsb_value = v; lsb_robid = r;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_cdb(input string tag, input logic v, input logic [31:0] val,
                              input logic [3:0] r, input logic s);
        chk({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        chk({tag, "_value"}, 64'(cdb_value), 64'(val));
        chk({tag, "_robid"}, 64'(cdb_robid), 64'(r));
        chk({tag, "_src"},   64'(cdb_src),   64'(s));
    endtask

    logic [35:0] qa[$];
    logic [35:0] ql[$];
    logic [35:0] exp_e;
    logic [31:0] nv;
    int unsigned na, nl, seen;
    logic        exp_src;

    initial begin
        rdy = 1'b1; pred_fail_flag = 1'b0; rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;

        // reset state
        expect_cdb("rst", 1'b0, 32'h0, 4'h0, 1'b0);
        chk("rst_taken",  64'(cdb_taken), 64'd0);
        chk("rst_target", 64'(cdb_target), 64'd0);
        chk("rst_astall", 64'(alu_stall), 64'd0);
        chk("rst_lstall", 64'(lsb_stall), 64'd0);
        chk("rst_ovf",    64'(overflow_err), 64'd0);

        // single ALU push: broadcast after the second edge, gone after the third
        push_a(32'h11, 4'd3, 1'b0, 32'h0);
        step(); idle();
        chk("t1_e1_valid", 64'(cdb_valid), 64'd0);
        chk("t1_e1_astall", 64'(alu_stall), 64'd1);
        step();
        expect_cdb("t1_e2", 1'b1, 32'h11, 4'd3, 1'b0);
        step();
        chk("t1_e3_valid", 64'(cdb_valid), 64'd0);
        chk("t1_e3_hold", 64'(cdb_value), 64'h11);

        // simultaneous push after reset: ALU first, then LSB
        do_reset();
        push_a(32'hA, 4'd1, 1'b1, 32'h100);
        push_l(32'hB, 4'd2);
        step(); idle();
        chk("t2_e1_valid", 64'(cdb_valid), 64'd0);
        step();
        expect_cdb("t2_alu", 1'b1, 32'hA, 4'd1, 1'b0);
        chk("t2_alu_taken",  64'(cdb_taken), 64'd1);
        chk("t2_alu_target", 64'(cdb_target), 64'h100);
        step();
        expect_cdb("t2_lsb", 1'b1, 32'hB, 4'd2, 1'b1);
        chk("t2_lsb_taken",  64'(cdb_taken), 64'd0);
        chk("t2_lsb_target", 64'(cdb_target), 64'h0);
        step();
        chk("t2_end_valid", 64'(cdb_valid), 64'd0);

        // both sources push whenever not stalled: strict alternation, FIFO order
        do_reset();
        na = 0; nl = 0; seen = 0; exp_src = 1'b0;
        for (int i = 0; i < 24; i++) begin
            idle();
            if (i < 20 && !alu_stall) begin
                nv = 32'h1000 + na;
                push_a(nv, 4'(na), nv[0], 32'h2000 + na);
                qa.push_back({alu_robid, alu_value});
                na++;
            end
            if (i < 20 && !lsb_stall) begin
                push_l(32'h3000 + nl, 4'(nl + 8));
                ql.push_back({lsb_robid, lsb_value});
                nl++;
            end
            step();
            if (cdb_valid) begin
                chk("t3_src", 64'(cdb_src), 64'(exp_src));
                if (exp_src == 1'b0) begin
                    chk("t3_a_avail", 64'(qa.size() > 0), 64'd1);
                    if (qa.size() > 0) begin
                        exp_e = qa.pop_front();
                        chk("t3_a_data", 64'({cdb_robid, cdb_value}), 64'(exp_e));
                        chk("t3_a_taken", 64'(cdb_taken), 64'(exp_e[0]));
                    end
                end else begin
                    chk("t3_l_avail", 64'(ql.size() > 0), 64'd1);
                    if (ql.size() > 0) begin
                        exp_e = ql.pop_front();
                        chk("t3_l_data", 64'({cdb_robid, cdb_value}), 64'(exp_e));
                    end
                end
                exp_src = ~exp_src;
                seen++;
            end
        end
        idle();
        chk("t3_pushes", 64'(na + nl), 64'd20);
        chk("t3_seen",   64'(seen), 64'd20);
        chk("t3_qa_empty", 64'(qa.size()), 64'd0);
        chk("t3_ql_empty", 64'(ql.size()), 64'd0);
        chk("t3_ovf", 64'(overflow_err), 64'd0);

        // LSB overfill while losing the tie to the ALU
        do_reset();
        push_a(32'h40, 4'd0, 1'b0, 32'h0); push_l(32'h50, 4'd8);
        step();
        chk("t4_e1_lstall", 64'(lsb_stall), 64'd1);
        push_a(32'h41, 4'd1, 1'b0, 32'h0); push_l(32'h51, 4'd9);
        step();
        expect_cdb("t4_e2", 1'b1, 32'h40, 4'd0, 1'b0);
        chk("t4_e2_lstall", 64'(lsb_stall), 64'd1);
        chk("t4_e2_ovf", 64'(overflow_err), 64'd0);
        push_a(32'h42, 4'd2, 1'b0, 32'h0); push_l(32'h52, 4'd10);
        step();
        expect_cdb("t4_e3", 1'b1, 32'h50, 4'd8, 1'b1);
        chk("t4_e3_ovf", 64'(overflow_err), 64'd0);
        idle(); push_l(32'h53, 4'd11);
        step(); idle();
        expect_cdb("t4_e4", 1'b1, 32'h41, 4'd1, 1'b0);
        chk("t4_e4_ovf", 64'(overflow_err), 64'd1);
        step();
        expect_cdb("t4_e5", 1'b1, 32'h51, 4'd9, 1'b1);
        step();
        expect_cdb("t4_e6", 1'b1, 32'h42, 4'd2, 1'b0);
        step();
        expect_cdb("t4_e7", 1'b1, 32'h52, 4'd10, 1'b1);
        step();
        chk("t4_e8_valid", 64'(cdb_valid), 64'd0);
        chk("t4_e8_ovf", 64'(overflow_err), 64'd1);

        // flush with both FIFOs occupied and a live broadcast
        push_a(32'h60, 4'd6, 1'b0, 32'h0); push_l(32'h70, 4'd7);
        step();
        push_a(32'h61, 4'd12, 1'b0, 32'h0); push_l(32'h71, 4'd13);
        step();
        expect_cdb("t5_pre", 1'b1, 32'h60, 4'd6, 1'b0);
        idle(); push_a(32'h62, 4'd14, 1'b0, 32'h0);
        pred_fail_flag = 1'b1;
        step();
        pred_fail_flag = 1'b0; idle();
        expect_cdb("t5_flush", 1'b0, 32'h0, 4'd0, 1'b0);
        chk("t5_astall", 64'(alu_stall), 64'd0);
        chk("t5_lstall", 64'(lsb_stall), 64'd0);
        chk("t5_ovf", 64'(overflow_err), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_quiet", 64'(cdb_valid), 64'd0);
        end

        // rdy low freezes the bus and ignores pushes
        do_reset();
        push_a(32'h80, 4'd5, 1'b0, 32'h0); push_l(32'h90, 4'd9);
        step();
        idle(); push_a(32'h81, 4'd6, 1'b0, 32'h0);
        step();
        expect_cdb("t6_pre", 1'b1, 32'h80, 4'd5, 1'b0);
        rdy = 1'b0;
        push_a(32'h82, 4'd7, 1'b0, 32'h0); push_l(32'h92, 4'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cdb("t6_hold", 1'b1, 32'h80, 4'd5, 1'b0);
        end
        rdy = 1'b1; idle();
        step();
        expect_cdb("t6_r1", 1'b1, 32'h90, 4'd9, 1'b1);
        step();
        expect_cdb("t6_r2", 1'b1, 32'h81, 4'd6, 1'b0);
        step();
        chk("t6_r3_valid", 64'(cdb_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
